// File: rtl/trigger_gen_pkg.sv
// Shared encodings for the trigger controller and the downstream state machine it drives.
package trigger_gen_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_FIRE = 2'd1,
    T_ACK  = 2'd2,
    T_GAP  = 2'd3
  } tstate_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/trig_pend_cnt.sv
// Saturating up/down count of outstanding requests, with a sticky flag for dropped requests.
module trig_pend_cnt #(
  parameter int DEPTH = 7,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] DMAX = W'(DEPTH);

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    // An increment and a decrement in the same cycle cancel, even when full.
    if (inc_i && !dec_i) begin
      if (count_q < DMAX) count_d = count_q + 1'b1;
      else                ovf_d   = 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/trigger_gen.sv
// Queues start requests and issues them one at a time to a downstream FSM, waiting for DONE
// (or a timeout) and an idle gap between consecutive triggers.
module trigger_gen
  import trigger_gen_pkg::*;
#(
  parameter int DEPTH   = 7,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] sm_state,
  output logic       trigger,
  output logic [2:0] pending,
  output logic       busy,
  output logic       overflow,
  output logic       err
);

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam tstate_e    ACK_EXIT = (GAP == 0) ? T_IDLE : T_GAP;

  tstate_e    state_q, state_d;
  logic [7:0] ack_cnt_q, ack_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       err_q, err_d;

  trig_pend_cnt #(.DEPTH(DEPTH), .W(3)) u_pend (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (req),
    .dec_i      (trigger),
    .count_o    (pending),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = '0;
    gap_cnt_d = '0;
    err_d     = err_q;
    case (state_q)
      T_IDLE: if (pending != 3'd0 && sm_state == S_IDLE) state_d = T_FIRE;
      T_FIRE: state_d = T_ACK;
      T_ACK: begin
        // DONE wins over a timeout expiring in the same cycle.
        if (sm_state == S_DONE) begin
          state_d = ACK_EXIT;
        end else if (ack_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ACK_EXIT;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      T_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = T_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= T_IDLE;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
    end
  end

  assign trigger = (state_q == T_FIRE);
  assign busy    = (state_q != T_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen with default parameters (DEPTH=7, GAP=2, TIMEOUT=8).
module tb_trigger_gen;

  logic       clk;
  logic       rst;
  logic       req;
  logic [1:0] sm_state;
  logic       trigger;
  logic [2:0] pending;
  logic       busy;
  logic       overflow;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic       nominal;
  logic [1:0] ds;
  logic       prev_trig;

  trigger_gen dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .sm_state (sm_state),
    .trigger  (trigger),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; optional nominal downstream goes RUN, WAIT, DONE, IDLE after a trigger.
  task automatic step();
    prev_trig = trigger;
    @(posedge clk);
    #1;
    if (nominal) begin
      if (prev_trig)      ds = 2'd1;
      else if (ds != 2'd0) ds = (ds == 2'd3) ? 2'd0 : ds + 2'd1;
      sm_state = ds;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; nominal = 1'b0; ds = 2'd0; sm_state = 2'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d want=0", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL reset_trigger got=%0b want=0", trigger); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err); end
  endtask

  task automatic test_latency();
    do_reset();
    nominal = 1'b1;
    req = 1'b1;
    step();
    req = 1'b0;
    checks++; if (pending !== 3'd1) begin failures++; $display("FAIL lat_pending_n1 got=%0d want=1", pending); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL lat_trigger_n1 got=%0b want=0", trigger); end
    step();
    checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL lat_trigger_n2 got=%0b want=1", trigger); end
    step();
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL lat_trigger_n3 got=%0b want=0", trigger); end
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL lat_pending_n3 got=%0d want=0", pending); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy_n3 got=%0b want=1", busy); end
  endtask

  task automatic test_back_to_back();
    int tc[$];
    do_reset();
    nominal = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (trigger === 1'b1) tc.push_back(c);
      if (c == 3) begin
        checks++; if (pending !== 3'd2) begin failures++; $display("FAIL b2b_pending_c3 got=%0d want=2", pending); end
      end
      if (c == 16) begin
        checks++; if (pending !== 3'd1) begin failures++; $display("FAIL b2b_pending_c16 got=%0d want=1", pending); end
      end
      if (c == 17) begin
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL b2b_pending_c17 got=%0d want=0", pending); end
      end
      req = (c < 3);
      step();
    end
    req = 1'b0;
    checks++;
    if (tc.size() != 3) begin
      failures++; $display("FAIL b2b_trigger_count got=%0d want=3", tc.size());
    end else if (tc[0] != 2 || tc[1] != 9 || tc[2] != 16) begin
      failures++; $display("FAIL b2b_trigger_cycles got=%0d,%0d,%0d want=2,9,16", tc[0], tc[1], tc[2]);
    end
  endtask

  task automatic test_overflow();
    int ntrig = 0;
    do_reset();
    sm_state = 2'd1;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) begin
        checks++; if (pending !== 3'd7 || overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_before got=p%0d/o%0b want=p7/o0", pending, overflow);
        end
      end
      req = 1'b1;
      step();
      if (trigger === 1'b1) ntrig++;
    end
    req = 1'b0;
    step();
    if (trigger === 1'b1) ntrig++;
    checks++; if (pending !== 3'd7) begin failures++; $display("FAIL ovf_pending got=%0d want=7", pending); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    checks++; if (ntrig != 0) begin failures++; $display("FAIL ovf_no_trigger got=%0d want=0", ntrig); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy got=%0b want=0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    sm_state = 2'd0;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL to_trigger got=%0b want=1", trigger); end
    for (int c = 3; c <= 10; c++) step();
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL to_ack_last got=e%0b/b%0b want=e0/b1", err, busy);
    end
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_set got=%0b want=1", err); end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_gap2_busy got=%0b want=1", busy); end
    step();
    checks++; if (busy !== 1'b0 || trigger !== 1'b0) begin
      failures++; $display("FAIL to_idle got=b%0b/t%0b want=b0/t0", busy, trigger);
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0b want=1", err); end
  endtask

  // Continues from the idle, err=1 state left by test_timeout.
  task automatic test_reset_mid();
    sm_state = 2'd0;
    for (int c = 0; c < 4; c++) begin
      req = 1'b1;
      step();
    end
    req = 1'b0;
    checks++; if (pending !== 3'd3 || busy !== 1'b1 || trigger !== 1'b0) begin
      failures++; $display("FAIL mid_pre got=p%0d/b%0b/t%0b want=p3/b1/t0", pending, busy, trigger);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pending !== 3'd0) begin failures++; $display("FAIL mid_pending got=%0d want=0", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b want=0", busy); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL mid_trigger got=%0b want=0", trigger); end
    checks++; if (err !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_flags got=e%0b/o%0b want=e0/o0", err, overflow);
    end
    step();
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL mid_no_trigger_after got=%0b want=0", trigger); end
  endtask

  task automatic test_coincident();
    do_reset();
    sm_state = 2'd1;
    for (int c = 0; c < 7; c++) begin
      req = 1'b1;
      step();
    end
    req = 1'b0;
    sm_state = 2'd0;
    step();
    checks++; if (trigger !== 1'b1 || pending !== 3'd7) begin
      failures++; $display("FAIL coin_fire got=t%0b/p%0d want=t1/p7", trigger, pending);
    end
    req = 1'b1;
    step();
    req = 1'b0;
    checks++; if (pending !== 3'd7) begin failures++; $display("FAIL coin_pending got=%0d want=7", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL coin_overflow got=%0b want=0", overflow); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL coin_single_pulse got=%0b want=0", trigger); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; sm_state = 2'd0; nominal = 1'b0; ds = 2'd0; prev_trig = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
